turn_scheduler: RTL and testbench
=================================

TURN_SCHEDULER -- requirements
Module: turn_scheduler

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500000000, is the number of cycles a player has to enter a move (10 s at 50 MHz).
REQ-002 Parameter CHECK_LAT, default 2, is the number of cycles after a move strobe in which illegal_move is sampled.
REQ-003 clk  input  1  system clock, 50 MHz; the only clock.
REQ-004 reset_n  input  1  reset; asynchronous assert, active-low.
REQ-005 key_flag  input  1  one-cycle strobe: key_value is valid.
REQ-006 key_value  input  4  decoded board cell, 1..9; 0 means not a cell.
REQ-007 illegal_move  input  1  game engine rejects the last move (level).
REQ-008 over  input  1  game engine reports the game finished (level).
REQ-009 move_P1_i  output  1  one-cycle move strobe for player 1.
REQ-010 move_P2_i  output  1  one-cycle move strobe for player 2.
REQ-011 move_P1  output  4  cell for player 1; held until the next P1 issue.
REQ-012 move_P2  output  4  cell for player 2; held until the next P2 issue.
REQ-013 turn  output  1  player to move: 0 = P1, 1 = P2.
REQ-014 timeout  output  1  one-cycle pulse when a turn is forfeited.
REQ-015 busy  output  1  high in the ISSUE and CHECK states.

Function
REQ-016 The block SHALL implement four states:
- WAIT: waiting for the current player's key.
- ISSUE: one cycle; drives the move strobe.
- CHECK: samples illegal_move.
- DONE: game over.
REQ-017 In WAIT, key_flag=1 with key_value in 1..9 SHALL latch key_value into move_P1 or move_P2 (selected by turn) and go to ISSUE on the next cycle.
REQ-018 In WAIT, key_flag=1 with key_value of 0 or 10..15 SHALL be ignored: no state change, timeout counter not cleared.
REQ-019 ISSUE SHALL assert exactly one of move_P1_i or move_P2_i (selected by turn) for exactly one cycle, then go to CHECK.
- Strobe latency from the key_flag cycle: 1 cycle.
REQ-020 CHECK SHALL last CHECK_LAT cycles.
- If illegal_move=1 in any of those cycles: return to WAIT with turn unchanged.
- Otherwise: toggle turn and return to WAIT.
REQ-021 key_flag in ISSUE, CHECK or DONE SHALL be dropped; keys are not queued.
REQ-022 A 29-bit timeout counter SHALL count only in WAIT.
- Cleared when leaving WAIT and when it expires.
- In WAIT, count value TIMEOUT_CYCLES-1 pulses timeout for one cycle, toggles turn and stays in WAIT.
REQ-023 If key_flag with a valid key arrives in the same cycle the counter expires, the key SHALL win: move issued, no timeout pulse, turn unchanged.
REQ-024 over=1 SHALL force DONE from any state on the next cycle.
- Exception: the ISSUE strobe already in progress completes.
REQ-025 DONE is exited only by reset.
- DONE holds move_P1, move_P2 and turn; no strobes or timeouts are generated.
REQ-026 move_P1_i and move_P2_i SHALL never be high in the same cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 reset_n=0 SHALL asynchronously force:
- state WAIT, turn=0 (P1 moves first);
- move_P1=0, move_P2=0;
- move_P1_i=0, move_P2_i=0, timeout=0, busy=0;
- timeout counter 0.
REQ-029 Reset during ISSUE or CHECK SHALL abort the move; no strobe appears after reset is released until a new valid key arrives.

Structure
REQ-030 State encodings, the player-ID constants (P1=0, P2=1) and the defaults of TIMEOUT_CYCLES and CHECK_LAT SHALL live in a shared game package used by game_ctrl and this block.
REQ-031 The timeout counter SHALL be a sub-module named turn_timer (ports: clear, enable, expire); everything else is flat.

Verification
REQ-032 Reset, then key 5 -> one cycle later move_P1_i=1 with move_P1=5; after CHECK_LAT cycles with illegal_move=0, turn=1.
REQ-033 P2 key 5 with illegal_move=1 in CHECK -> turn stays 1; a following key 7 gives move_P2_i=1 with move_P2=7.
REQ-034 TIMEOUT_CYCLES=16, no keys -> timeout pulses at WAIT cycle 16 and turn toggles; repeats every 16 cycles.
REQ-035 Key 3 in the same cycle the counter expires -> move_P1_i issued, no timeout pulse; key 0 or key 12 -> no strobe.
REQ-036 over=1 during CHECK -> DONE; later keys 1..9 produce no strobes; reset_n pulse -> WAIT with turn=0.

Source files
------------

// File: rtl/turn_scheduler_pkg.sv
// Shared game definitions: scheduler state encoding, player IDs and timing defaults.
// Imported by the turn scheduler and by the game controller.
package turn_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic PLAYER_P1 = 1'b0;
  localparam logic PLAYER_P2 = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 500000000;
  localparam int unsigned CHECK_LAT_DEF      = 2;
  localparam int          TIMER_W            = 29;

  function automatic logic is_cell(input logic [3:0] v);
    return (v >= 4'd1) && (v <= 4'd9);
  endfunction

endpackage

// File: rtl/turn_scheduler_timer.sv
// Move timeout counter: counts while enabled, expire is combinational on the last count.
// Expiry or clear returns the count to zero on the next edge.
module turn_timer
  import turn_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] r_cnt;

  assign expire = enable && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (clear || expire) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/turn_scheduler.sv
// Two-player turn scheduler: key -> registered move strobe one cycle later, then a
// CHECK_LAT-cycle legality window decides whether the turn passes; idle turns time out.
module turn_scheduler
  import turn_scheduler_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned CHECK_LAT      = CHECK_LAT_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_flag,
  input  logic [3:0] key_value,
  input  logic       illegal_move,
  input  logic       over,
  output logic       move_P1_i,
  output logic       move_P2_i,
  output logic [3:0] move_P1,
  output logic [3:0] move_P2,
  output logic       turn,
  output logic       timeout,
  output logic       busy
);

  localparam int CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;

  state_t         r_state, w_state_nxt;
  logic           r_turn, w_turn_nxt;
  logic [3:0]     r_move_p1, w_move_p1_nxt;
  logic [3:0]     r_move_p2, w_move_p2_nxt;
  logic           r_stb_p1, w_stb_p1_nxt;
  logic           r_stb_p2, w_stb_p2_nxt;
  logic           r_timeout, w_timeout_nxt;
  logic           r_busy, w_busy_nxt;
  logic [CW-1:0]  r_chk, w_chk_nxt;
  logic           r_ill, w_ill_nxt;
  logic           w_key_ok;
  logic           w_in_wait;
  logic           w_timer_clr;
  logic           w_expire;

  assign w_key_ok  = key_flag && is_cell(key_value);
  assign w_in_wait = (r_state == ST_WAIT);

  // Counter only runs while parked in WAIT; any exit from WAIT restarts it.
  assign w_timer_clr = !w_in_wait || (w_state_nxt != ST_WAIT);

  turn_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_timer_clr),
    .enable  (w_in_wait),
    .expire  (w_expire)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_turn_nxt    = r_turn;
    w_move_p1_nxt = r_move_p1;
    w_move_p2_nxt = r_move_p2;
    w_stb_p1_nxt  = 1'b0;
    w_stb_p2_nxt  = 1'b0;
    w_timeout_nxt = 1'b0;
    w_chk_nxt     = r_chk;
    w_ill_nxt     = r_ill;
    case (r_state)
      ST_WAIT: begin
        if (over) begin
          w_state_nxt = ST_DONE;
        end else if (w_key_ok) begin
          w_state_nxt = ST_ISSUE;
          if (r_turn == PLAYER_P2) begin
            w_move_p2_nxt = key_value;
            w_stb_p2_nxt  = 1'b1;
          end else begin
            w_move_p1_nxt = key_value;
            w_stb_p1_nxt  = 1'b1;
          end
        end else if (w_expire) begin
          w_timeout_nxt = 1'b1;
          w_turn_nxt    = ~r_turn;
        end
      end
      ST_ISSUE: begin
        w_chk_nxt   = '0;
        w_ill_nxt   = 1'b0;
        w_state_nxt = over ? ST_DONE : ST_CHECK;
      end
      ST_CHECK: begin
        if (over) begin
          w_state_nxt = ST_DONE;
        end else if (r_chk == CW'(CHECK_LAT - 1)) begin
          w_state_nxt = ST_WAIT;
          if (!(r_ill || illegal_move)) w_turn_nxt = ~r_turn;
        end else begin
          w_chk_nxt = r_chk + CW'(1);
          w_ill_nxt = r_ill || illegal_move;
        end
      end
      ST_DONE: w_state_nxt = ST_DONE;
      default: w_state_nxt = ST_WAIT;
    endcase
    w_busy_nxt = (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_CHECK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_WAIT;
      r_turn    <= PLAYER_P1;
      r_move_p1 <= '0;
      r_move_p2 <= '0;
      r_stb_p1  <= 1'b0;
      r_stb_p2  <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_chk     <= '0;
      r_ill     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_turn    <= w_turn_nxt;
      r_move_p1 <= w_move_p1_nxt;
      r_move_p2 <= w_move_p2_nxt;
      r_stb_p1  <= w_stb_p1_nxt;
      r_stb_p2  <= w_stb_p2_nxt;
      r_timeout <= w_timeout_nxt;
      r_busy    <= w_busy_nxt;
      r_chk     <= w_chk_nxt;
      r_ill     <= w_ill_nxt;
    end
  end

  assign move_P1_i = r_stb_p1;
  assign move_P2_i = r_stb_p2;
  assign move_P1   = r_move_p1;
  assign move_P2   = r_move_p2;
  assign turn      = r_turn;
  assign timeout   = r_timeout;
  assign busy      = r_busy;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: directed scenarios plus random play, every cycle compared
// against a move-progress reference model.
module tb_turn_scheduler;

  localparam int TO = 16;
  localparam int CL = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       key_flag = 1'b0;
  logic [3:0] key_value = 4'd0;
  logic       illegal_move = 1'b0;
  logic       over = 1'b0;
  logic       move_P1_i, move_P2_i, turn, timeout, busy;
  logic [3:0] move_P1, move_P2;

  turn_scheduler #(
    .TIMEOUT_CYCLES (TO),
    .CHECK_LAT      (CL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .key_flag     (key_flag),
    .key_value    (key_value),
    .illegal_move (illegal_move),
    .over         (over),
    .move_P1_i    (move_P1_i),
    .move_P2_i    (move_P2_i),
    .move_P1      (move_P1),
    .move_P2      (move_P2),
    .turn         (turn),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference: m_pos is how far into a move we are (0 = waiting for a key,
  // 1 = strobe cycle, 2..CL+1 = legality window); m_idle counts waiting cycles.
  int         m_pos, m_idle;
  bit         m_done, m_turn, m_ill;
  logic [3:0] m_p1, m_p2;
  bit         e_s1, e_s2, e_to;

  function automatic void model_reset();
    m_pos = 0; m_idle = 0; m_done = 0; m_turn = 0; m_ill = 0;
    m_p1 = 4'd0; m_p2 = 4'd0; e_s1 = 0; e_s2 = 0; e_to = 0;
  endfunction

  function automatic void model_step(input bit kf, input logic [3:0] kv, input bit ill, input bit ovr);
    e_s1 = 0; e_s2 = 0; e_to = 0;
    if (m_done) return;
    if (m_pos == 0) begin
      if (ovr) begin
        m_done = 1; m_idle = 0;
      end else if (kf && kv >= 1 && kv <= 9) begin
        if (m_turn) begin m_p2 = kv; e_s2 = 1; end
        else begin m_p1 = kv; e_s1 = 1; end
        m_pos = 1; m_idle = 0; m_ill = 0;
      end else begin
        m_idle++;
        if (m_idle == TO) begin e_to = 1; m_turn = !m_turn; m_idle = 0; end
      end
    end else if (ovr) begin
      m_done = 1; m_pos = 0; m_ill = 0;
    end else begin
      if (m_pos >= 2) m_ill = m_ill | ill;
      if (m_pos == CL + 1) begin
        if (!m_ill) m_turn = !m_turn;
        m_pos = 0; m_ill = 0;
      end else begin
        m_pos++;
      end
    end
  endfunction

  task automatic compare_all();
    check("stb_p1",  32'(move_P1_i), 32'(e_s1));
    check("stb_p2",  32'(move_P2_i), 32'(e_s2));
    check("move_p1", 32'(move_P1),   32'(m_p1));
    check("move_p2", 32'(move_P2),   32'(m_p2));
    check("turn",    32'(turn),      32'(m_turn));
    check("timeout", 32'(timeout),   32'(e_to));
    check("busy",    32'(busy),      32'(m_pos != 0));
    check("excl",    32'(move_P1_i & move_P2_i), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_step(key_flag, key_value, illegal_move, over);
    #1 compare_all();
  endtask

  task automatic do_reset();
    key_flag = 1'b0; over = 1'b0;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic key(input logic [3:0] v);
    key_flag = 1'b1; key_value = v;
    tick();
    key_flag = 1'b0;
  endtask

  int to_cnt;

  initial begin
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    reset_n = 1'b1;

    // First move for P1, legal
    key(4'd5);
    check("r032_stb", 32'(move_P1_i), 32'd1);
    check("r032_cell", 32'(move_P1), 32'd5);
    repeat (3) tick();
    check("r032_turn", 32'(turn), 32'd1);

    // P2 rejected move keeps the turn, retry is issued for P2
    illegal_move = 1'b1;
    key(4'd5);
    repeat (3) tick();
    illegal_move = 1'b0;
    check("r033_turn", 32'(turn), 32'd1);
    key(4'd7);
    check("r033_stb", 32'(move_P2_i), 32'd1);
    check("r033_cell", 32'(move_P2), 32'd7);
    repeat (3) tick();

    // Idle turns time out every TO cycles
    to_cnt = 0;
    for (int i = 0; i < 4 * TO; i++) begin
      tick();
      to_cnt += int'(timeout);
    end
    check("r034_count", 32'(to_cnt), 32'd4);

    // Key on the expiry cycle wins
    repeat (TO - 1) tick();
    key(4'd3);
    check("r035_stb", 32'(move_P1_i), 32'd1);
    check("r035_noto", 32'(timeout), 32'd0);
    repeat (3) tick();
    key(4'd0);
    check("r035_k0", 32'(move_P1_i | move_P2_i), 32'd0);
    key(4'd12);
    check("r035_k12", 32'(move_P1_i | move_P2_i), 32'd0);

    // Game over during CHECK locks the block until reset
    key(4'd4);
    tick();
    over = 1'b1;
    tick();
    over = 1'b0;
    check("r036_busy", 32'(busy), 32'd0);
    for (int v = 1; v <= 9; v++) begin
      key(4'(v));
      check("r036_nostb", 32'(move_P1_i | move_P2_i), 32'd0);
    end
    repeat (2 * TO) tick();
    do_reset();
    check("r036_turn", 32'(turn), 32'd0);

    // Reset in the strobe cycle aborts the move
    key(4'd2);
    do_reset();
    repeat (6) tick();

    // Random play
    for (int seg = 0; seg < 30; seg++) begin
      int dens;
      dens = int'($urandom_range(0, 20));
      for (int c = 0; c < 100; c++) begin
        key_flag     = ($urandom_range(0, 99) < dens);
        key_value    = 4'($urandom_range(0, 15));
        illegal_move = ($urandom_range(0, 3) == 0);
        over         = ($urandom_range(0, 299) == 0);
        tick();
        if (m_done && $urandom_range(0, 9) == 0) do_reset();
      end
    end
    key_flag = 1'b0; illegal_move = 1'b0; over = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
